// File: rtl/shape_processor_ctrl_bank.sv
// Bank of NUM_CHANNELS shape processor CTRL SFRs with checked writes and per-channel busy windows.
// Optional macro SHAPE_PROCESSOR_ERR_STATUS_EN adds a sticky W1C error status register at address NUM_CHANNELS.
module shape_processor_ctrl_bank #(
    parameter int NUM_CHANNELS = 4,
    parameter int BUSY_CYCLES  = 3,
    parameter int ADDR_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write,
    input  logic [ADDR_W-1:0]       write_addr,
    input  logic [31:0]             write_data,
    input  logic                    read,
    input  logic [ADDR_W-1:0]       read_addr,
    output logic [31:0]             read_data,
    output logic                    read_valid,
    output logic                    error,
    output logic [NUM_CHANNELS-1:0] busy
);
    localparam int CNT_W = (BUSY_CYCLES < 1) ? 1 : $clog2(BUSY_CYCLES + 1);
    localparam logic [ADDR_W-1:0] NCH_ADDR = ADDR_W'(NUM_CHANNELS);

    localparam logic [2:0] SH_CIRCLE = 3'd0, SH_RECT = 3'd1, SH_TRI = 3'd2, SH_KEEP = 3'd7;
    localparam logic [2:0] OP_PERIM = 3'd0, OP_AREA = 3'd1, OP_SQUARE = 3'd2;
    localparam logic [2:0] OP_EQUI = 3'd3, OP_ISO = 3'd4, OP_KEEP = 3'd7;

    function automatic logic legal(input logic [2:0] sh, input logic [2:0] op);
        case (op)
            OP_PERIM, OP_AREA: return sh inside {SH_CIRCLE, SH_RECT, SH_TRI};
            OP_SQUARE:         return sh == SH_RECT;
            OP_EQUI, OP_ISO:   return sh == SH_TRI;
            default:           return 1'b0;
        endcase
    endfunction

    logic [2:0]       shape_q  [NUM_CHANNELS];
    logic [2:0]       op_q     [NUM_CHANNELS];
    logic [CNT_W-1:0] busy_cnt [NUM_CHANNELS];

    logic [2:0]  w_sh, w_op, cur_sh, cur_op, eff_sh, eff_op;
    logic        cur_busy, wr_in_range, both_keep, wr_ok, wr_err, wr_update;
    logic        rd_hit, rd_err;
    logic [31:0] rd_word;
    logic        unused_ok;

    assign w_sh      = write_data[2:0];
    assign w_op      = write_data[6:4];
    assign unused_ok = ^{write_data[31:7], write_data[3]};

`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
    logic [NUM_CHANNELS-1:0] err_status, status_set;
    logic                    wr_status;
    assign wr_status = write && (write_addr == NCH_ADDR);
`endif

    always_comb begin
        cur_sh   = SH_CIRCLE;
        cur_op   = OP_PERIM;
        cur_busy = 1'b0;
        rd_word  = '0;
        rd_hit   = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (write_addr == ADDR_W'(i)) begin
                cur_sh   = shape_q[i];
                cur_op   = op_q[i];
                cur_busy = (busy_cnt[i] != '0);
            end
            if (read_addr == ADDR_W'(i)) begin
                rd_word = {25'd0, op_q[i], 1'b0, shape_q[i]};
                rd_hit  = 1'b1;
            end
        end
`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
        if (read_addr == NCH_ADDR) begin
            rd_word = 32'(err_status);
            rd_hit  = 1'b1;
        end
`endif
        // KEEP fields take the current SFR value before the legality check.
        eff_sh      = (w_sh == SH_KEEP) ? cur_sh : w_sh;
        eff_op      = (w_op == OP_KEEP) ? cur_op : w_op;
        wr_in_range = (write_addr < NCH_ADDR);
        both_keep   = (w_sh == SH_KEEP) && (w_op == OP_KEEP);
        wr_ok       = wr_in_range && !(w_sh inside {[3'd3:3'd6]}) && !(w_op inside {3'd5, 3'd6})
                      && !cur_busy && legal(eff_sh, eff_op);
`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
        wr_err      = write && !wr_ok && !wr_status;
`else
        wr_err      = write && !wr_ok;
`endif
        wr_update   = write && wr_ok && !both_keep;
        rd_err      = read && !rd_hit;
    end

`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
    always_comb begin
        status_set = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            status_set[i] = wr_err && (write_addr == ADDR_W'(i));
    end
`endif

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            busy[i] = (busy_cnt[i] != '0);
    end

    // read_valid pulses one cycle after each read strobe; there is no back-pressure on either port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shape_q[i]  <= SH_CIRCLE;
                op_q[i]     <= OP_PERIM;
                busy_cnt[i] <= '0;
            end
            read_data  <= '0;
            read_valid <= 1'b0;
            error      <= 1'b0;
`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
            err_status <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_update && (write_addr == ADDR_W'(i))) begin
                    if (w_sh != SH_KEEP) shape_q[i] <= w_sh;
                    if (w_op != OP_KEEP) op_q[i]    <= w_op;
                    busy_cnt[i] <= CNT_W'(BUSY_CYCLES);
                end else if (busy_cnt[i] != '0) begin
                    busy_cnt[i] <= busy_cnt[i] - CNT_W'(1);
                end
            end
            read_valid <= read;
            read_data  <= read ? rd_word : '0;
            error      <= wr_err || rd_err;
`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
            // A set in the same cycle as a clear wins.
            err_status <= (err_status & ~(wr_status ? write_data[NUM_CHANNELS-1:0] : '0)) | status_set;
`endif
        end
    end
endmodule

// File: tb/tb_shape_processor_ctrl_bank.sv
// Self-checking bench for shape_processor_ctrl_bank: directed scenarios plus a model-driven random run.
module tb_shape_processor_ctrl_bank;
    localparam int NCH  = 4;
    localparam int BUSY = 3;
    localparam int AW   = 4;

    logic           clk = 1'b0;
    logic           rst, write, read;
    logic [AW-1:0]  write_addr, read_addr;
    logic [31:0]    write_data, read_data;
    logic           read_valid, error;
    logic [NCH-1:0] busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    shape_processor_ctrl_bank #(.NUM_CHANNELS(NCH), .BUSY_CYCLES(BUSY), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .write(write), .write_addr(write_addr), .write_data(write_data),
        .read(read), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid),
        .error(error), .busy(busy)
    );

    // Scoreboard: every read pushes its expected word, every read_valid pops one.
    always @(negedge clk) begin
        if (read_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: read_valid=1 read_data=%h, no read outstanding", read_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (read_data !== exp_v) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", read_data, exp_v);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [31:0] d);
        write = 1'b1; write_addr = a; write_data = d;
        step();
        write = 1'b0; write_data = '0;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        read = 1'b1; read_addr = a;
        step();
        read = 1'b0;
    endtask

    task automatic drive_rw(input logic [AW-1:0] wa, input logic [31:0] wd,
                            input logic [AW-1:0] ra, input logic [31:0] e);
        exp_q.push_back(e);
        write = 1'b1; write_addr = wa; write_data = wd;
        read = 1'b1; read_addr = ra;
        step();
        write = 1'b0; read = 1'b0; write_data = '0;
    endtask

    function automatic logic legal_m(input logic [2:0] sh, input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1) return sh <= 3'd2;
        if (op == 3'd2) return sh == 3'd1;
        if (op == 3'd3 || op == 3'd4) return sh == 3'd2;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        drive_write(1, 32'h21);
        n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
        n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", read_valid); end
        n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", read_data); end
        rst = 1'b0;
        drive_read(0, 32'h0);
        n_checks++; if (read_valid !== 1'b1) begin n_fail++; $display("FAIL reset_rvalid_t1: got %b expected 1", read_valid); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_rd_error: got %b expected 0", error); end
        for (int ch = 1; ch < NCH; ch++) drive_read(AW'(ch), 32'h0);
        step();
        n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL rvalid_single: got %b expected 0", read_valid); end
    endtask

    task automatic test_busy_window();
        drive_write(1, 32'h21);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL sq_error: got %b expected 0", error); end
        n_checks++; if (busy !== 4'b0010) begin n_fail++; $display("FAIL sq_busy_t1: got %b expected 0010", busy); end
        drive_read(1, 32'h21);
        n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL sq_busy_t2: got %b expected 1", busy[1]); end
        drive_write(1, 32'h01);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL busy_reject: got %b expected 1", error); end
        n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL sq_busy_t3: got %b expected 1", busy[1]); end
        drive_write(1, 32'h11);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL busy_last_reject: got %b expected 1", error); end
        n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL sq_busy_t4: got %b expected 0", busy[1]); end
        step();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL busy_err_pulse: got %b expected 0", error); end
        drive_read(1, 32'h21);
    endtask

    task automatic test_illegal_combo();
        drive_write(2, 32'h22);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tri_square: got %b expected 1", error); end
        n_checks++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL tri_square_busy: got %b expected 0", busy[2]); end
        step();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 0", error); end
        drive_read(2, 32'h0);
        drive_write(2, 32'h05);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL reserved_shape: got %b expected 1", error); end
        drive_write(2, 32'h52);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL reserved_op: got %b expected 1", error); end
        drive_read(2, 32'h0);
    endtask

    task automatic test_keep();
        drive_write(0, 32'h32);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL tri_equi: got %b expected 0", error); end
        idle(3);
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL busy_expire: got %b expected 0", busy[0]); end
        drive_read(0, 32'h32);
        drive_write(0, 32'h07);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL keep_shape_err: got %b expected 0", error); end
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL keep_shape_busy: got %b expected 1", busy[0]); end
        idle(3);
        drive_read(0, 32'h02);
        drive_write(0, 32'h77);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL keep_both_err: got %b expected 0", error); end
        n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL keep_both_busy: got %b expected 0000", busy); end
        drive_read(0, 32'h02);
        drive_write(0, 32'h71);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL keep_op_err: got %b expected 0", error); end
        idle(3);
        drive_write(0, 32'h37);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL keep_illegal: got %b expected 1", error); end
        drive_read(0, 32'h01);
    endtask

    task automatic test_out_of_range();
`ifndef SHAPE_PROCESSOR_ERR_STATUS_EN
        drive_write(4, 32'h01);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL oor_wr4: got %b expected 1", error); end
        n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL oor_wr4_busy: got %b expected 0000", busy); end
        drive_read(4, 32'h0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL oor_rd4: got %b expected 1", error); end
`endif
        drive_write(9, 32'h01);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL oor_wr9: got %b expected 1", error); end
        drive_read(9, 32'h0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL oor_rd9: got %b expected 1", error); end
        drive_read(0, 32'h01);
        drive_read(1, 32'h21);
        drive_read(2, 32'h00);
        drive_read(3, 32'h00);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL oor_clean: got %b expected 0", error); end
    endtask

    task automatic test_back_to_back();
        drive_write(2, 32'h12);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL b2b_ch2: got %b expected 0", error); end
        drive_write(3, 32'h42);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL b2b_ch3: got %b expected 0", error); end
        drive_write(1, 32'h11);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL b2b_ch1: got %b expected 0", error); end
        n_checks++; if (busy !== 4'b1110) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1110", busy); end
        drive_read(0, 32'h01);
        drive_read(1, 32'h11);
        drive_read(2, 32'h12);
        drive_read(3, 32'h42);
    endtask

    task automatic test_simultaneous();
        idle(3);
        drive_rw(2, 32'h02, 2, 32'h12);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rw_same_err: got %b expected 0", error); end
        drive_read(2, 32'h02);
        drive_rw(3, 32'h22, 9, 32'h0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL rw_both_err: got %b expected 1", error); end
        step();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rw_err_pulse: got %b expected 0", error); end
        drive_read(3, 32'h42);
    endtask

`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
    task automatic test_err_status();
        rst = 1'b1; step(); rst = 1'b0;
        drive_write(0, 32'h05);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL st_rej0: got %b expected 1", error); end
        drive_write(3, 32'h22);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL st_rej3: got %b expected 1", error); end
        drive_read(4, 32'h9);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL st_rd_err: got %b expected 0", error); end
        drive_write(4, 32'h1);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL st_w1c_err: got %b expected 0", error); end
        drive_read(4, 32'h8);
        drive_write(1, 32'h01);
        n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL st_busy: got %b expected 1", busy[1]); end
        rst = 1'b1; step(); rst = 1'b0;
        n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL st_rst_busy: got %b expected 0000", busy); end
        drive_read(4, 32'h0);
        drive_read(1, 32'h0);
    endtask
`endif

    task automatic test_random();
        logic [2:0]    m_sh[NCH];
        logic [2:0]    m_op[NCH];
        int            m_busy[NCH];
        logic [AW-1:0] wa, ra;
        logic [31:0]   wd;
        logic          do_w, do_r, ok, wr_e, rd_e, upd;
        logic [2:0]    wsh, wop, esh, eop;
        logic [NCH-1:0] exp_busy;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < NCH; i++) begin m_sh[i] = 3'd0; m_op[i] = 3'd0; m_busy[i] = 0; end
        for (int it = 0; it < 300; it++) begin
            do_w = 1'($urandom_range(0, 1));
            do_r = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, 4)); if (wa == 4) wa = 5;
            ra = AW'($urandom_range(0, 4)); if (ra == 4) ra = 5;
            wd = $urandom;
            wsh = wd[2:0]; wop = wd[6:4];
            ok = 1'b0;
            if (wa < NCH) begin
                esh = (wsh == 3'd7) ? m_sh[wa] : wsh;
                eop = (wop == 3'd7) ? m_op[wa] : wop;
                ok = !(wsh >= 3'd3 && wsh <= 3'd6) && !(wop == 3'd5 || wop == 3'd6)
                     && (m_busy[wa] == 0) && legal_m(esh, eop);
            end
            wr_e = do_w && !ok;
            upd  = do_w && ok && !(wsh == 3'd7 && wop == 3'd7);
            rd_e = do_r && (ra >= NCH);
            if (do_r) exp_q.push_back((ra < NCH) ? {25'd0, m_op[ra], 1'b0, m_sh[ra]} : 32'h0);
            write = do_w; write_addr = wa; write_data = wd;
            read = do_r; read_addr = ra;
            step();
            write = 1'b0; read = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (upd && wa == AW'(i)) begin
                    if (wsh != 3'd7) m_sh[i] = wsh;
                    if (wop != 3'd7) m_op[i] = wop;
                    m_busy[i] = BUSY;
                end else if (m_busy[i] > 0) begin
                    m_busy[i]--;
                end
                exp_busy[i] = (m_busy[i] != 0);
            end
            n_checks++; if (error !== (wr_e | rd_e)) begin n_fail++; $display("FAIL rnd_error it=%0d: got %b expected %b", it, error, wr_e | rd_e); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy it=%0d: got %b expected %b", it, busy, exp_busy); end
        end
        step();
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; read = 1'b0;
        write_addr = '0; read_addr = '0; write_data = '0;
        test_reset();
        test_busy_window();
        test_illegal_combo();
        test_keep();
        test_out_of_range();
        test_back_to_back();
        test_simultaneous();
`ifdef SHAPE_PROCESSOR_ERR_STATUS_EN
        test_err_status();
`endif
        test_random();
        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_missing: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
